// File: rtl/pconv_fmap_collector_pkg.sv
// Shared definitions for the feature-map collector: FSM state encoding,
// default geometry and an index-width helper that never returns zero.
package pconv_fmap_collector_pkg;

  localparam int DEF_N          = 16;
  localparam int DEF_CHANNEL    = 32;
  localparam int DEF_INPUT_SIZE = 6;
  localparam int DEF_PIX        = DEF_INPUT_SIZE * DEF_INPUT_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A depth of 1 still needs a 1-bit index so ports never collapse to zero width.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEF_PIX_W = idx_w(DEF_PIX);
  localparam int DEF_CH_W  = idx_w(DEF_CHANNEL);

endpackage

// File: rtl/pconv_fmap_collector_fmap_buf_bank.sv
// PIX x (CHANNEL*N) register array: full-vector write, single-lane read mux.
module fmap_buf_bank
  import pconv_fmap_collector_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int CHANNEL = DEF_CHANNEL,
  parameter int PIX     = DEF_PIX,
  localparam int PIX_W  = idx_w(PIX),
  localparam int CH_W   = idx_w(CHANNEL)
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [PIX_W-1:0]     waddr_i,
  input  logic [CHANNEL*N-1:0] wdata_i,
  input  logic [PIX_W-1:0]     raddr_i,
  input  logic [CH_W-1:0]      rch_i,
  output logic [N-1:0]         rdata_o
);

  logic [CHANNEL*N-1:0] mem_q [PIX];
  logic [CHANNEL*N-1:0] row;

  // NOTE: storage has no reset; the FSM never presents a row before it is written.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign row     = mem_q[raddr_i];
  assign rdata_o = row[rch_i*N +: N];

endmodule

// File: rtl/pconv_fmap_collector.sv
// Captures one CHANNEL-lane feature map in raster order, replays it channel-major.
// Optional FMAP_COLLECT_RELU_EN: lanes with MSB set are stored as zero.
module pconv_fmap_collector
  import pconv_fmap_collector_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int CHANNEL    = DEF_CHANNEL,
  parameter int INPUT_SIZE = DEF_INPUT_SIZE,
  localparam int PIX       = INPUT_SIZE * INPUT_SIZE,
  localparam int PIX_W     = idx_w(PIX),
  localparam int CH_W      = idx_w(CHANNEL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_vld,
  input  logic [CHANNEL*N-1:0] din,
  output logic                 din_rdy,
  output logic [N-1:0]         dout,
  output logic                 dout_vld,
  input  logic                 dout_rdy,
  output logic [CH_W-1:0]      dout_ch,
  output logic                 dout_last,
  output logic                 ovf
);

  state_e             state_q;
  logic [PIX_W-1:0]   wr_cnt_q;
  logic [PIX_W-1:0]   rd_pix_q;
  logic [CH_W-1:0]    rd_ch_q;
  logic               ovf_q;

  logic                 buf_we;
  logic [CHANNEL*N-1:0] buf_wdata;
  logic [N-1:0]         rd_lane;
  logic                 last_elem;

  assign buf_we    = din_vld && (state_q != ST_DRAIN);
  assign last_elem = (rd_ch_q == CH_W'(CHANNEL - 1)) && (rd_pix_q == PIX_W'(PIX - 1));

  always_comb begin
    buf_wdata = din;
`ifdef FMAP_COLLECT_RELU_EN
    for (int c = 0; c < CHANNEL; c++) begin
      if (din[c*N + N - 1]) buf_wdata[c*N +: N] = '0;
    end
`endif
  end

  fmap_buf_bank #(
    .N       (N),
    .CHANNEL (CHANNEL),
    .PIX     (PIX)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (wr_cnt_q),
    .wdata_i (buf_wdata),
    .raddr_i (rd_pix_q),
    .rch_i   (rd_ch_q),
    .rdata_o (rd_lane)
  );

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_cnt_q <= '0;
      rd_pix_q <= '0;
      rd_ch_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (din_vld) begin
            if (PIX == 1) begin
              wr_cnt_q <= '0;
              state_q  <= ST_DRAIN;
            end else begin
              wr_cnt_q <= PIX_W'(1);
              state_q  <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (din_vld) begin
            if (wr_cnt_q == PIX_W'(PIX - 1)) begin
              wr_cnt_q <= '0;
              state_q  <= ST_DRAIN;
            end else begin
              wr_cnt_q <= wr_cnt_q + PIX_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (din_vld) ovf_q <= 1'b1;
          if (dout_rdy) begin
            if (last_elem) begin
              rd_pix_q <= '0;
              rd_ch_q  <= '0;
              state_q  <= ST_IDLE;
            end else if (rd_pix_q == PIX_W'(PIX - 1)) begin
              rd_pix_q <= '0;
              rd_ch_q  <= rd_ch_q + CH_W'(1);
            end else begin
              rd_pix_q <= rd_pix_q + PIX_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs derive only from registered state, so dout_rdy never reaches dout_vld.
  assign din_rdy   = (state_q != ST_DRAIN);
  assign dout_vld  = (state_q == ST_DRAIN);
  assign dout      = dout_vld ? rd_lane : '0;
  assign dout_ch   = rd_ch_q;
  assign dout_last = dout_vld && last_elem;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pconv_fmap_collector.sv
// Directed bench for pconv_fmap_collector at N=16, CHANNEL=4, INPUT_SIZE=2.
module tb_pconv_fmap_collector;

  localparam int N   = 16;
  localparam int CH  = 4;
  localparam int IS  = 2;
  localparam int PIX = IS * IS;
  localparam int TOT = CH * PIX;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            din_vld = 1'b0;
  logic [CH*N-1:0] din = '0;
  logic            din_rdy;
  logic [N-1:0]    dout;
  logic            dout_vld;
  logic            dout_rdy = 1'b0;
  logic [1:0]      dout_ch;
  logic            dout_last;
  logic            ovf;

  int checks   = 0;
  int failures = 0;
  logic [N-1:0] model [PIX][CH];

  pconv_fmap_collector #(.N(N), .CHANNEL(CH), .INPUT_SIZE(IS)) dut (
    .clk       (clk),
    .rst       (rst),
    .din_vld   (din_vld),
    .din       (din),
    .din_rdy   (din_rdy),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .dout_rdy  (dout_rdy),
    .dout_ch   (dout_ch),
    .dout_last (dout_last),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] lane_val(input int base, input bit special, input int p, input int c);
    if (special && p == 0) begin
      case (c)
        0:       return 16'h8001;
        1:       return 16'h7FFF;
        2:       return 16'hFFFF;
        default: return 16'h0000;
      endcase
    end
    return N'(base + 16*p + c);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dout_vld"}, 32'(dout_vld), 32'd0);
    check({tag, "_din_rdy"},  32'(din_rdy),  32'd1);
    check({tag, "_dout"},     32'(dout),     32'd0);
    check({tag, "_dout_ch"},  32'(dout_ch),  32'd0);
    check({tag, "_dout_last"},32'(dout_last),32'd0);
  endtask

  // Reset is sampled at the posedge between two negedges; outputs checked right after.
  task automatic do_reset(input string tag);
    rst = 1'b1; din_vld = 1'b0; dout_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs(tag);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  // Called at a negedge; drives nbeats vectors with optional idle gaps before each.
  task automatic fill(input int nbeats, input bit gaps, input int base, input bit special);
    for (int p = 0; p < nbeats; p++) begin
      int gap;
      gap = gaps ? 1 + (p % 3) : 0;
      for (int g = 0; g < gap; g++) begin
        din_vld = 1'b0;
        @(negedge clk);
      end
      for (int c = 0; c < CH; c++) begin
        logic [N-1:0] v;
        v = lane_val(base, special, p, c);
        din[c*N +: N] = v;
`ifdef FMAP_COLLECT_RELU_EN
        model[p][c] = v[N-1] ? '0 : v;
`else
        model[p][c] = v;
`endif
      end
      din_vld = 1'b1;
      check($sformatf("fill_rdy_p%0d", p), 32'(din_rdy), 32'd1);
      check($sformatf("fill_novld_p%0d", p), 32'(dout_vld), 32'd0);
      @(negedge clk);
    end
    din_vld = 1'b0;
  endtask

  // mode 0: always ready; 1: 1010 then 5 stalled cycles; 2: ready with din pulses.
  // abort_at >= 0 returns (still draining) once that many handshakes completed.
  task automatic drain(input string tag, input int mode, input int abort_at);
    int k   = 0;
    int cyc = 0;
    while (k < TOT && cyc < 100) begin
      int p, c;
      bit rdy;
      if (k == abort_at) break;
      p = k % PIX;
      c = k / PIX;
      check($sformatf("%s_vld_k%0d", tag, k),  32'(dout_vld), 32'd1);
      check($sformatf("%s_rdy_k%0d", tag, k),  32'(din_rdy),  32'd0);
      check($sformatf("%s_dout_k%0d", tag, k), 32'(dout),     32'(model[p][c]));
      check($sformatf("%s_ch_k%0d", tag, k),   32'(dout_ch),  32'(c));
      check($sformatf("%s_last_k%0d", tag, k), 32'(dout_last), 32'(k == TOT - 1));
      case (mode)
        1:       rdy = (cyc < 8) ? (cyc % 2 == 0) : (cyc >= 13);
        default: rdy = 1'b1;
      endcase
      dout_rdy = rdy;
      din_vld  = (mode == 2) && (cyc == 3 || k == TOT - 1);
      din      = {CH{16'hDEAD}};
      if (rdy) k++;
      cyc++;
      @(negedge clk);
    end
    din_vld  = 1'b0;
    dout_rdy = 1'b0;
    if (abort_at < 0) begin
      check({tag, "_done"}, 32'(k), 32'(TOT));
      check_idle_outputs({tag, "_post"});
    end else begin
      check({tag, "_abort_k"}, 32'(k), 32'(abort_at));
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset("reset");

    // 1: straight fill and drain
    fill(PIX, 1'b0, 0, 1'b0);
    drain("t1", 0, -1);
    check("t1_ovf", 32'(ovf), 32'd0);

    // 2: stalled drain
    fill(PIX, 1'b0, 0, 1'b0);
    drain("t2", 1, -1);
    check("t2_ovf", 32'(ovf), 32'd0);

    // 3: beats during drain are dropped and set sticky ovf
    fill(PIX, 1'b0, 0, 1'b0);
    drain("t3", 2, -1);
    check("t3_ovf", 32'(ovf), 32'd1);
    fill(PIX, 1'b0, 300, 1'b0);
    drain("t3b", 0, -1);
    check("t3b_ovf", 32'(ovf), 32'd1);

    // 4: gaps between input beats
    fill(PIX, 1'b1, 0, 1'b0);
    drain("t4", 0, -1);

    // 5: reset mid-fill, then mid-drain, then a fresh map
    do_reset("t5_rst0");
    fill(2, 1'b0, 0, 1'b0);
    do_reset("t5_rst1");
    fill(PIX, 1'b0, 0, 1'b0);
    drain("t5a", 0, 6);
    do_reset("t5_rst2");
    fill(PIX, 1'b0, 1000, 1'b0);
    drain("t5b", 0, -1);

    // 6: sign-bit lanes (zeroed only with ReLU fused)
    fill(PIX, 1'b0, 0, 1'b1);
    drain("t6", 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
